// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types for the sequential ALU
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  typedef enum logic {
    ITER_MUL = 1'b0,
    ITER_DIV = 1'b1
  } iter_mode_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  function automatic logic is_iter_op(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - one-bit-per-cycle shift-add multiplier / restoring divider
module alu_iter_unit
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  iter_mode_t   mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi
);

  logic [N-1:0] lo_r;
  logic [N-1:0] hi_r;
  logic [N-1:0] m_r;
  iter_mode_t   mode_r;

  logic [N:0]   sum;
  logic [N:0]   shifted;
  logic [N-1:0] diff;
  logic         ge;

  // lo/hi show the state after the step in progress, so the owner can latch
  // the final value on the same edge that completes the Nth step.
  always_comb begin
    sum     = {1'b0, hi_r} + {1'b0, m_r};
    shifted = {hi_r, lo_r[N-1]};
    ge      = (shifted >= {1'b0, m_r});
    diff    = shifted[N-1:0] - m_r;
    lo      = lo_r;
    hi      = hi_r;
    if (mode_r == ITER_MUL) begin
      if (lo_r[0]) begin
        hi = sum[N:1];
        lo = {sum[0], lo_r[N-1:1]};
      end else begin
        hi = {1'b0, hi_r[N-1:1]};
        lo = {hi_r[0], lo_r[N-1:1]};
      end
    end else begin
      if (ge) begin
        hi = diff;
        lo = {lo_r[N-2:0], 1'b1};
      end else begin
        hi = shifted[N-1:0];
        lo = {lo_r[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_r   <= '0;
      hi_r   <= '0;
      m_r    <= '0;
      mode_r <= ITER_MUL;
    end else if (load) begin
      lo_r   <= a;
      hi_r   <= '0;
      m_r    <= b;
      mode_r <= mode;
    end else begin
      lo_r   <= lo;
      hi_r   <= hi;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with IDLE/EXEC/DONE handshake
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         dbz,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  alu_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_load;
  alu_op_t       op_in, op_r;
  logic [N-1:0]  a_r, b_r;
  logic          accept;
  iter_mode_t    iter_mode;
  logic [N-1:0]  iter_lo, iter_hi;

  logic [N:0]    add_w, sub_w;
  logic [N-1:0]  res_c, hi_c;
  logic          c_c, v_c, dbz_c;
  alu_flags_t    flags_r;

  assign op_in     = alu_op_t'(op);
  assign accept    = (state != ST_EXEC) && start;
  assign iter_mode = ((op_in == OP_DIV) || (op_in == OP_MOD)) ? ITER_DIV : ITER_MUL;

  // Divide by zero needs no iteration, so it shares the single-cycle path.
  always_comb begin
    cnt_load = CW'(1);
    if (is_iter_op(op_in) && !((op_in != OP_MUL) && (b == '0)))
      cnt_load = CW'(N);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_EXEC;
          cnt_nxt   = cnt_load;
        end
      end
      ST_EXEC: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_EXEC;
          cnt_nxt   = cnt_load;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_r  <= OP_ADD;
      a_r   <= '0;
      b_r   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_r <= op_in;
        a_r  <= a;
        b_r  <= b;
      end
    end
  end

  alu_iter_unit #(.N(N)) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .mode (iter_mode),
    .a    (a),
    .b    (b),
    .lo   (iter_lo),
    .hi   (iter_hi)
  );

  always_comb begin
    add_w = {1'b0, a_r} + {1'b0, b_r};
    sub_w = {1'b0, a_r} - {1'b0, b_r};
    res_c = '0;
    hi_c  = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    dbz_c = 1'b0;
    case (op_r)
      OP_ADD: begin
        res_c = add_w[N-1:0];
        c_c   = add_w[N];
        v_c   = (a_r[N-1] == b_r[N-1]) && (add_w[N-1] != a_r[N-1]);
      end
      OP_SUB: begin
        res_c = sub_w[N-1:0];
        c_c   = sub_w[N];
        v_c   = (a_r[N-1] != b_r[N-1]) && (sub_w[N-1] != a_r[N-1]);
      end
      OP_MUL: begin
        res_c = iter_lo;
        hi_c  = iter_hi;
        c_c   = (iter_hi != '0);
      end
      OP_DIV: begin
        dbz_c = (b_r == '0);
        res_c = dbz_c ? '1 : iter_lo;
      end
      OP_MOD: begin
        dbz_c = (b_r == '0);
        res_c = dbz_c ? a_r : iter_hi;
      end
      OP_AND:  res_c = a_r & b_r;
      OP_OR:   res_c = a_r | b_r;
      OP_XOR:  res_c = a_r ^ b_r;
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      flags_r   <= '0;
      dbz       <= 1'b0;
    end else if ((state == ST_EXEC) && (state_nxt == ST_DONE)) begin
      result    <= res_c;
      result_hi <= hi_c;
      flags_r   <= '{n: res_c[N-1], z: ((res_c == '0) && (hi_c == '0)), c: c_c, v: v_c};
      dbz       <= dbz_c;
    end
  end

  assign flag_n = flags_r.n;
  assign flag_z = flags_r.z;
  assign flag_c = flags_r.c;
  assign flag_v = flags_r.v;
  assign busy   = (state == ST_EXEC);
  assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

  localparam int N = 4;
  localparam int M = 1 << N;
  localparam int H = 1 << (N - 1);

  typedef struct {
    int res;
    int hi;
    int n;
    int z;
    int c;
    int v;
    int dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [2:0]   op = '0;
  logic [N-1:0] result, result_hi;
  logic         flag_n, flag_z, flag_c, flag_v, dbz, busy, done;

  exp_t sb[$];
  int   checks = 0;
  int   errs = 0;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .op        (op),
    .result    (result),
    .result_hi (result_hi),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .dbz       (dbz),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= H) ? x - M : x;
  endfunction

  function automatic exp_t model(input int o, input int x, input int y);
    exp_t e;
    int   s;
    e = '{default: 0};
    case (o)
      0: begin
        s = x + y;
        e.res = s % M;
        e.c = (s >= M);
        s = to_signed(x) + to_signed(y);
        e.v = (s >= H) || (s < -H);
      end
      1: begin
        e.res = (x - y + M) % M;
        e.c = (x < y);
        s = to_signed(x) - to_signed(y);
        e.v = (s >= H) || (s < -H);
      end
      2: begin
        s = x * y;
        e.res = s % M;
        e.hi = s / M;
        e.c = (e.hi != 0);
      end
      3: begin
        e.dbz = (y == 0);
        e.res = (y == 0) ? M - 1 : x / y;
      end
      4: begin
        e.dbz = (y == 0);
        e.res = (y == 0) ? x : x % y;
      end
      5: e.res = x & y;
      6: e.res = x | y;
      default: e.res = x ^ y;
    endcase
    e.z = (e.res == 0) && (e.hi == 0);
    e.n = (e.res >= H);
    return e;
  endfunction

  function automatic int edges_for(input int o, input int y);
    return (o == 2 || ((o == 3 || o == 4) && y != 0)) ? N + 1 : 2;
  endfunction

  // Monitor: every done pulse consumes the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result", int'(result), e.res);
        chk("result_hi", int'(result_hi), e.hi);
        chk("flag_n", int'(flag_n), e.n);
        chk("flag_z", int'(flag_z), e.z);
        chk("flag_c", int'(flag_c), e.c);
        chk("flag_v", int'(flag_v), e.v);
        chk("dbz", int'(dbz), e.dbz);
        chk("busy_in_done", int'(busy), 0);
      end
    end
  end

  task automatic send(input int o, input int x, input int y, input bit hold);
    @(negedge clk);
    op = 3'(o);
    a = N'(x);
    b = N'(y);
    start = 1'b1;
    sb.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int exp_edges, input string tag);
    int k;
    int bc;
    k = 1;
    bc = busy ? 1 : 0;
    while (k < 60) begin
      @(posedge clk);
      k++;
      #1;
      if (done) break;
      bc += busy ? 1 : 0;
    end
    chk({tag, "_latency"}, k, exp_edges);
    chk({tag, "_busy_cycles"}, bc, exp_edges - 1);
  endtask

  initial begin
    int o, x, y;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({flag_n, flag_z, flag_c, flag_v, dbz}), 0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;

    send(0, 15, 8, 0);
    wait_done(2, "add");
    chk("add_lit", int'({flag_c, flag_v, result}), 'b110111);

    send(1, 15, 15, 0);
    wait_done(2, "sub");
    chk("sub_lit", int'({flag_z, flag_c, flag_v, result}), 'b1000000);

    send(2, 11, 11, 0);
    wait_done(5, "mul");
    chk("mul_lit", int'({flag_c, result_hi, result}), 'b101111001);

    send(3, 10, 2, 1);
    op = 3'd4;
    a = 4'd10;
    b = 4'd2;
    sb.push_back(model(4, 10, 2));
    wait_done(5, "div_b2b");
    chk("div_lit", int'(result), 5);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, "mod_b2b");
    chk("mod_lit", int'({flag_z, result}), 'b10000);

    send(3, 8, 0, 0);
    wait_done(2, "div0");
    chk("div0_lit", int'({dbz, result}), 'b11111);

    send(2, 11, 11, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outputs", int'({result_hi, result, flag_n, flag_z, flag_c, flag_v, dbz}), 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    send(2, 7, 9, 0);
    wait_done(5, "after_abort");

    for (int i = 0; i < 40; i++) begin
      o = int'($urandom_range(0, 7));
      x = int'($urandom_range(0, M - 1));
      y = (i % 8 == 3) ? 0 : int'($urandom_range(0, M - 1));
      send(o, x, y, 0);
      wait_done(edges_for(o, y), "rand");
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
